// File: rtl/cache_axi_rd_arbiter.sv
// Arbitrates the icache and dcache refill/uncached reads onto one AXI4 AR/R channel
// and assembles R beats into a cache line. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module cache_axi_rd_arbiter #(
  parameter int unsigned LINE_BEATS = 4,
  parameter logic [3:0]  IC_ARID    = 4'd0,
  parameter logic [3:0]  DC_ARID    = 4'd1
) (
  input  logic                       clk_g,
  input  logic                       resetn,
  input  logic                       ic_rd_req,
  input  logic                       ic_rd_uncache,
  input  logic [31:0]                ic_rd_addr,
  output logic                       ic_rd_rdy,
  output logic                       ic_ret_valid,
  output logic [32*LINE_BEATS-1:0]   ic_ret_data,
  input  logic                       dc_rd_req,
  input  logic                       dc_rd_uncache,
  input  logic [31:0]                dc_rd_addr,
  output logic                       dc_rd_rdy,
  output logic                       dc_ret_valid,
  output logic [32*LINE_BEATS-1:0]   dc_ret_data,
  output logic [3:0]                 arid,
  output logic [31:0]                araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [3:0]                 rid,
  input  logic [31:0]                rdata,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready
);

  localparam int unsigned     LINE_W     = 32 * LINE_BEATS;
  localparam int unsigned     CNT_W      = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int unsigned     OFS_W      = $clog2(LINE_BEATS * 4);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);
  localparam logic [7:0]      CACHED_LEN = 8'(LINE_BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;      // 1 = dcache owns the transaction
  logic               uncache_q, uncache_d;
  logic [31:0]        araddr_q, araddr_d;
  logic [7:0]         arlen_q, arlen_d;
  logic [3:0]         arid_q, arid_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [LINE_W-1:0]  line_q, line_d;

  logic               grant_dc;
  logic [31:0]        win_addr;
  logic               win_unc;
  logic [CNT_W-1:0]   slot;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // On a tie the cache that did not win last time goes first.
  assign grant_dc     = dc_rd_req && (!ic_rd_req || !last_owner_q);
  assign last_owner_d = (state_q == S_IDLE && (ic_rd_req || dc_rd_req)) ? grant_dc : last_owner_q;

  always_ff @(posedge clk_g) begin
    if (!resetn) last_owner_q <= 1'b0;
    else         last_owner_q <= last_owner_d;
  end
`else
  assign grant_dc = dc_rd_req;
`endif

  assign win_addr = grant_dc ? dc_rd_addr    : ic_rd_addr;
  assign win_unc  = grant_dc ? dc_rd_uncache : ic_rd_uncache;

  // Single outstanding transaction makes rid redundant.
  logic unused_rid;
  assign unused_rid = ^rid;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    uncache_d    = uncache_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arid_d       = arid_q;
    beat_cnt_d   = beat_cnt_q;
    line_d       = line_q;
    slot         = beat_cnt_q;
    arvalid      = 1'b0;
    rready       = 1'b0;
    ic_rd_rdy    = 1'b0;
    dc_rd_rdy    = 1'b0;
    ic_ret_valid = 1'b0;
    dc_ret_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ic_rd_req || dc_rd_req) begin
          owner_d    = grant_dc;
          uncache_d  = win_unc;
          araddr_d   = win_unc ? win_addr : {win_addr[31:OFS_W], {OFS_W{1'b0}}};
          arlen_d    = win_unc ? 8'd0 : CACHED_LEN;
          arid_d     = grant_dc ? DC_ARID : IC_ARID;
          beat_cnt_d = '0;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          ic_rd_rdy = ~owner_q;
          dc_rd_rdy = owner_q;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          // Uncached words always land in the top slot; extra beats keep hitting the last slot.
          slot = uncache_q ? LAST_BEAT : beat_cnt_q;
          line_d[32*slot +: 32] = rdata;
          if (beat_cnt_q != LAST_BEAT) beat_cnt_d = beat_cnt_q + 1'b1;
          if (rlast) state_d = S_DONE;
        end
      end
      S_DONE: begin
        ic_ret_valid = ~owner_q;
        dc_ret_valid = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      uncache_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arid_q     <= '0;
      beat_cnt_q <= '0;
      // NOTE: the line buffer is reset because it drives ret_data directly on both ports.
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      uncache_q  <= uncache_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arid_q     <= arid_d;
      beat_cnt_q <= beat_cnt_d;
      line_q     <= line_d;
    end
  end

  assign araddr      = araddr_q;
  assign arlen       = arlen_q;
  assign arid        = arid_q;
  assign arsize      = 3'b010;
  assign arburst     = 2'b01;
  assign ic_ret_data = line_q;
  assign dc_ret_data = line_q;

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed, table-driven bench for cache_axi_rd_arbiter: per-transaction vectors plus
// hand-written arbitration and mid-transaction reset sequences.
module tb_cache_axi_rd_arbiter;

  logic         clk_g = 1'b0;
  logic         resetn;
  logic         ic_rd_req, ic_rd_uncache, ic_rd_rdy, ic_ret_valid;
  logic [31:0]  ic_rd_addr;
  logic [127:0] ic_ret_data;
  logic         dc_rd_req, dc_rd_uncache, dc_rd_rdy, dc_ret_valid;
  logic [31:0]  dc_rd_addr;
  logic [127:0] dc_ret_data;
  logic [3:0]   arid, rid;
  logic [31:0]  araddr, rdata;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready, rlast, rvalid, rready;

  cache_axi_rd_arbiter dut (
    .clk_g(clk_g), .resetn(resetn),
    .ic_rd_req(ic_rd_req), .ic_rd_uncache(ic_rd_uncache), .ic_rd_addr(ic_rd_addr),
    .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_uncache(dc_rd_uncache), .dc_rd_addr(dc_rd_addr),
    .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk_g = ~clk_g;

  typedef struct packed {
    logic         dc;
    logic         unc;
    logic [31:0]  addr;
    logic [3:0]   ar_wait;
    logic [3:0]   nbeats;
    logic [31:0]  base;
    logic [23:0]  gaps;        // 4-bit idle-cycle count before each beat
    logic [31:0]  exp_araddr;
    logic [7:0]   exp_arlen;
    logic [127:0] exp_line;
  } vec_t;

  vec_t vecs [7];
  int   checks = 0;
  int   errors = 0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [2:0] ARB_EXP = 3'b101;  // bit i = 1 when round i goes to dcache
`else
  localparam logic [2:0] ARB_EXP = 3'b111;
`endif

  task automatic check(input string what, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  // Runs one transaction from an IDLE negedge to the IDLE negedge after ret_valid.
  task automatic run_txn(input int idx, input vec_t v, input bit raise);
    int lat;
    logic own_rv, oth_rv;
    lat = 0;
    if (raise) begin
      if (v.dc) begin dc_rd_req = 1'b1; dc_rd_uncache = v.unc; dc_rd_addr = v.addr; end
      else      begin ic_rd_req = 1'b1; ic_rd_uncache = v.unc; ic_rd_addr = v.addr; end
    end
    do begin @(negedge clk_g); #1; lat++; end while (!arvalid && lat < 8);
    check($sformatf("txn%0d ar_latency", idx), lat, 1);
    if (!arvalid) return;
    check($sformatf("txn%0d araddr", idx), araddr, v.exp_araddr);
    check($sformatf("txn%0d arlen", idx), arlen, v.exp_arlen);
    check($sformatf("txn%0d arid", idx), arid, v.dc ? 4'd1 : 4'd0);
    check($sformatf("txn%0d arsize_burst", idx), {arsize, arburst}, {3'b010, 2'b01});
    for (int i = 0; i < int'(v.ar_wait); i++) begin
      check($sformatf("txn%0d stall_arvalid", idx), arvalid, 1'b1);
      check($sformatf("txn%0d stall_ar", idx), {araddr, arlen}, {v.exp_araddr, v.exp_arlen});
      check($sformatf("txn%0d stall_rdy", idx), {dc_rd_rdy, ic_rd_rdy}, 2'b00);
      @(negedge clk_g); #1;
    end
    arready = 1'b1; #1;
    check($sformatf("txn%0d rd_rdy", idx), {dc_rd_rdy, ic_rd_rdy}, v.dc ? 2'b10 : 2'b01);
    @(negedge clk_g);
    arready = 1'b0;
    if (v.dc) dc_rd_req = 1'b0; else ic_rd_req = 1'b0;
    for (int b = 0; b < int'(v.nbeats); b++) begin
      for (int g = 0; g < int'(v.gaps[4*b +: 4]); g++) begin
        rvalid = 1'b0; #1;
        check($sformatf("txn%0d gap_rready", idx), {rready, ic_ret_valid, dc_ret_valid}, 3'b100);
        @(negedge clk_g);
      end
      rvalid = 1'b1; rdata = v.base + 32'(b); rlast = (b == int'(v.nbeats) - 1); #1;
      check($sformatf("txn%0d beat_rready", idx), {rready, ic_ret_valid, dc_ret_valid}, 3'b100);
      @(negedge clk_g);
    end
    rvalid = 1'b0; rlast = 1'b0; #1;
    own_rv = v.dc ? dc_ret_valid : ic_ret_valid;
    oth_rv = v.dc ? ic_ret_valid : dc_ret_valid;
    check($sformatf("txn%0d ret_valid", idx), {own_rv, oth_rv}, 2'b10);
    check($sformatf("txn%0d ret_data", idx), v.dc ? dc_ret_data : ic_ret_data, v.exp_line);
    @(negedge clk_g); #1;
    check($sformatf("txn%0d ret_once", idx), {ic_ret_valid, dc_ret_valid, arvalid, rready}, 4'b0000);
  endtask

  // Serves one uncached single-beat grant while both requests are held.
  task automatic serve(input int round, input bit exp_dc, input logic [31:0] data);
    int lat;
    lat = 0;
    do begin @(negedge clk_g); #1; lat++; end while (!arvalid && lat < 8);
    check($sformatf("arb%0d arvalid", round), arvalid, 1'b1);
    check($sformatf("arb%0d arid", round), arid, exp_dc ? 4'd1 : 4'd0);
    arready = 1'b1; #1;
    check($sformatf("arb%0d rd_rdy", round), {dc_rd_rdy, ic_rd_rdy}, exp_dc ? 2'b10 : 2'b01);
    @(negedge clk_g);
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = data;
    @(negedge clk_g);
    rvalid = 1'b0; rlast = 1'b0; #1;
    check($sformatf("arb%0d ret_valid", round), {dc_ret_valid, ic_ret_valid}, exp_dc ? 2'b10 : 2'b01);
    check($sformatf("arb%0d ret_word", round), exp_dc ? dc_ret_data[127:96] : ic_ret_data[127:96], data);
    @(negedge clk_g); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{dc:1'b0, unc:1'b0, addr:32'h1FC0_0014, ar_wait:4'd0, nbeats:4'd4, base:32'hA0,
                gaps:24'h0, exp_araddr:32'h1FC0_0010, exp_arlen:8'd3,
                exp_line:128'h000000A3_000000A2_000000A1_000000A0};
    vecs[1] = '{dc:1'b1, unc:1'b1, addr:32'hBFAF_8000, ar_wait:4'd0, nbeats:4'd1, base:32'h1234_5678,
                gaps:24'h0, exp_araddr:32'hBFAF_8000, exp_arlen:8'd0,
                exp_line:128'h12345678_000000A2_000000A1_000000A0};
    vecs[2] = '{dc:1'b1, unc:1'b0, addr:32'h0000_1238, ar_wait:4'd5, nbeats:4'd4, base:32'hB0,
                gaps:24'h004020, exp_araddr:32'h0000_1230, exp_arlen:8'd3,
                exp_line:128'h000000B3_000000B2_000000B1_000000B0};
    vecs[3] = '{dc:1'b0, unc:1'b0, addr:32'h0000_0100, ar_wait:4'd0, nbeats:4'd6, base:32'hC0,
                gaps:24'h0, exp_araddr:32'h0000_0100, exp_arlen:8'd3,
                exp_line:128'h000000C5_000000C2_000000C1_000000C0};
    vecs[4] = '{dc:1'b1, unc:1'b0, addr:32'h0000_0204, ar_wait:4'd1, nbeats:4'd2, base:32'hD0,
                gaps:24'h000010, exp_araddr:32'h0000_0200, exp_arlen:8'd3,
                exp_line:128'h000000C5_000000C2_000000D1_000000D0};
    vecs[5] = '{dc:1'b0, unc:1'b1, addr:32'h0000_0007, ar_wait:4'd0, nbeats:4'd1, base:32'hE0,
                gaps:24'h0, exp_araddr:32'h0000_0007, exp_arlen:8'd0,
                exp_line:128'h000000E0_000000C2_000000D1_000000D0};
    vecs[6] = '{dc:1'b0, unc:1'b0, addr:32'h0000_0404, ar_wait:4'd0, nbeats:4'd4, base:32'h50,
                gaps:24'h0, exp_araddr:32'h0000_0400, exp_arlen:8'd3,
                exp_line:128'h00000053_00000052_00000051_00000050};

    resetn = 1'b0;
    ic_rd_req = 1'b0; ic_rd_uncache = 1'b0; ic_rd_addr = '0;
    dc_rd_req = 1'b0; dc_rd_uncache = 1'b0; dc_rd_addr = '0;
    arready = 1'b0; rid = '0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) @(negedge clk_g);
    #1;
    check("reset ctrl", {arvalid, rready, ic_rd_rdy, dc_rd_rdy, ic_ret_valid, dc_ret_valid}, 6'b0);
    check("reset ar", {araddr, arid, arlen}, 44'h0);
    check("reset size_burst", {arsize, arburst}, {3'b010, 2'b01});
    check("reset line", {ic_ret_data, dc_ret_data}, 256'h0);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(i, vecs[i], 1'b1);

    // Simultaneous requests held across three grants, then icache alone.
    ic_rd_req = 1'b1; ic_rd_uncache = 1'b1; ic_rd_addr = 32'h0000_1000;
    dc_rd_req = 1'b1; dc_rd_uncache = 1'b1; dc_rd_addr = 32'h0000_2000;
    for (int r = 0; r < 3; r++) serve(r, ARB_EXP[r], 32'h600D_0000 + 32'(r));
    dc_rd_req = 1'b0;
    serve(3, 1'b0, 32'h600D_0003);
    ic_rd_req = 1'b0;
    repeat (3) begin
      @(negedge clk_g); #1;
      check("idle no_ar", {arvalid, ic_ret_valid, dc_ret_valid}, 3'b000);
    end

    // Reset during DATA after two beats, with a fresh icache request pending.
    ic_rd_req = 1'b1; ic_rd_uncache = 1'b0; ic_rd_addr = 32'h0000_0300;
    @(negedge clk_g); #1;
    check("abort arvalid", arvalid, 1'b1);
    arready = 1'b1;
    @(negedge clk_g);
    arready = 1'b0; ic_rd_req = 1'b0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1; rdata = 32'hF0 + 32'(b);
      @(negedge clk_g);
    end
    rvalid = 1'b0; resetn = 1'b0;
    ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_0404;
    @(negedge clk_g); #1;
    check("abort ctrl", {arvalid, rready, ic_ret_valid, dc_ret_valid}, 4'b0000);
    check("abort line", ic_ret_data, 128'h0);
    resetn = 1'b1;
    run_txn(6, vecs[6], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
